priority_arbiter32: RTL
=======================

PRIORITY_ARBITER32 -- requirements
Module: priority_arbiter32

Interface
REQ-001 Parameter RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, where the highest index wins.
REQ-002 Parameter MAX_HOLD, default 16: maximum number of cycles a grant is held while other requests are pending; legal range 2..255; 0 disables preemption.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low; deassertion sampled on the clk rising edge.
REQ-005 req  input  32  request vector; bit i is held high by requester i until it is done with the resource.
REQ-006 gnt  output  32  registered one-hot grant; all zeros when no grant is held.
REQ-007 gnt_vld  output  1  high when gnt is non-zero.
REQ-008 gnt_idx  output  5  binary index of the set gnt bit; 0 when gnt_vld=0.
REQ-009 preempt  output  1  one-cycle pulse in the cycle after a grant is revoked by the MAX_HOLD limit.

Function
REQ-010 Three states: IDLE, GRANT, GAP. Reset state is IDLE.
REQ-011 Selection, fixed priority: sel = onehot_highest(req).
REQ-012 Selection, round-robin:
- mask = bits with index < ptr.
- If (req & mask) != 0, sel = onehot_highest(req & mask); otherwise sel = onehot_highest(req).
REQ-013 IDLE or GAP with req != 0: load gnt <= sel, ptr <= index(sel), hold_cnt <= 0, and go to GRANT.
REQ-014 IDLE or GAP with req == 0: gnt stays 0; the next state is IDLE.
REQ-015 GRANT, releasing bit h where gnt[h]=1:
- If req[h]=0, then gnt <= 0 and go to GAP.
- Exactly one dead cycle separates successive grants.
REQ-016 GRANT, counting: if req[h]=1, hold_cnt increments, saturating at MAX_HOLD-1.
REQ-017 GRANT, preemption:
- Condition: MAX_HOLD != 0, hold_cnt == MAX_HOLD-1, req[h]=1, and (req & ~gnt) != 0.
- Action: gnt <= 0, preempt <= 1, go to GAP.
- The holder is not re-granted in that GAP if any other request exists; round-robin masking guarantees this.
REQ-018 With no competing request, the holder keeps the grant indefinitely, with hold_cnt saturated.
REQ-019 Latency: req rising in IDLE at edge n gives gnt at edge n+1.
REQ-020 Release timing: req[h] falling before edge n gives gnt=0 after edge n and a new grant after edge n+1.
REQ-021 Requests that change while in GRANT have no effect except through the release and preemption conditions.
REQ-022 gnt is always one-hot or zero; gnt_idx and gnt_vld are registered in the same cycle as gnt.
REQ-023 ptr wraps naturally: when ptr=0, mask is empty and the highest-index requester wins.

Reset
REQ-024 While rst=0, all of the following hold asynchronously: gnt=0, gnt_vld=0, gnt_idx=0, preempt=0, ptr=0, hold_cnt=0, state=IDLE.
REQ-025 Reset asserted mid-grant drops gnt immediately, with no GAP cycle.
REQ-026 The first arbitration happens on the first rising edge with rst=1.

Structure
REQ-027 A shared package holds:
- the state enum {IDLE, GRANT, GAP};
- the width constants NREQ=32 and IDXW=5.
REQ-028 Sub-module prio_onehot32 (combinational) returns the highest-index one-hot of a 32-bit vector and its 5-bit index.
REQ-029 prio_onehot32 is instantiated twice, once for the masked vector and once for the unmasked vector.
REQ-030 All outputs come directly from flops; there is no combinational path from req to any output.

Verification
REQ-031 Single request: req=0x0000_0010 after reset -> next cycle gnt=0x10, gnt_idx=4; after req drops -> gnt=0 for one cycle, then IDLE.
REQ-032 Fixed priority: RR_EN=0, req=0x8000_0001 held with repeated releases -> bit 31 always wins; bit 0 is never granted while bit 31 requests.
REQ-033 Round-robin, setup: RR_EN=1, req=0x0000_0111, each holder releases after 2 cycles and re-requests immediately.
REQ-034 Round-robin, required response: grant order 8, 4, 0, 8, 4, 0, each separated by one zero-gnt cycle.
REQ-035 Preemption: MAX_HOLD=4, req[7] held permanently, req[2] raised at grant cycle 1 -> gnt[7] lasts exactly 4 cycles, preempt pulses once, gap cycle follows, then gnt=0x04.
REQ-036 Reset mid-grant: rst=0 while gnt=0x20 -> gnt=0 before the next clk edge; after rst=1 with req=0x20 -> gnt=0x20 one edge later and ptr restarts from 0.

Source files
------------

// File: rtl/priority_arbiter32_pkg.sv
// Shared types and widths for the 32-way priority arbiter.
package priority_arbiter32_pkg;

    localparam int NREQ = 32;
    localparam int IDXW = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/priority_arbiter32_onehot.sv
// Highest-index one-hot finder: returns the one-hot of the top set bit and its index.
module prio_onehot32
    import priority_arbiter32_pkg::*;
(
    input  logic [NREQ-1:0] vec,
    output logic [NREQ-1:0] onehot,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (vec[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDXW'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter32.sv
// 32-requester arbiter with fixed or round-robin selection, a one-cycle gap
// between grants and optional preemption after MAX_HOLD cycles of contention.
module priority_arbiter32
    import priority_arbiter32_pkg::*;
#(
    parameter int RR_EN    = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            gnt_vld,
    output logic [IDXW-1:0] gnt_idx,
    output logic            preempt
);

    localparam logic [7:0] HOLD_SAT   = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD - 1);
    localparam bit         PREEMPT_EN = (MAX_HOLD != 0);

    state_t          state, state_nxt;
    logic [IDXW-1:0] ptr, ptr_nxt;
    logic [7:0]      hold_cnt, hold_cnt_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic            gnt_vld_nxt;
    logic [IDXW-1:0] gnt_idx_nxt;
    logic            preempt_nxt;

    logic [NREQ-1:0] mask, masked_req;
    logic [NREQ-1:0] sel_masked, sel_full, sel;
    logic [IDXW-1:0] idx_masked, idx_full, sel_idx;
    logic            found_masked, found_full;
    logic            holder_req, competitor, hold_expired;

    // Only indices below the last winner are eligible first, so the
    // previous holder drops to lowest priority on the next arbitration.
    assign mask       = (NREQ'(1) << ptr) - NREQ'(1);
    assign masked_req = req & mask;

    prio_onehot32 u_pick_masked (
        .vec    (masked_req),
        .onehot (sel_masked),
        .idx    (idx_masked),
        .found  (found_masked)
    );

    prio_onehot32 u_pick_full (
        .vec    (req),
        .onehot (sel_full),
        .idx    (idx_full),
        .found  (found_full)
    );

    always_comb begin
        sel     = sel_full;
        sel_idx = idx_full;
        if ((RR_EN != 0) && found_masked) begin
            sel     = sel_masked;
            sel_idx = idx_masked;
        end
    end

    assign holder_req   = |(req & gnt);
    assign competitor   = |(req & ~gnt);
    assign hold_expired = PREEMPT_EN && (hold_cnt == HOLD_SAT) && holder_req && competitor;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_vld  <= 1'b0;
            gnt_idx  <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            gnt      <= gnt_nxt;
            gnt_vld  <= gnt_vld_nxt;
            gnt_idx  <= gnt_idx_nxt;
            preempt  <= preempt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, GAP: state_nxt = found_full ? GRANT : IDLE;
            GRANT:     if (!holder_req || hold_expired) state_nxt = GAP;
            default:   state_nxt = IDLE;
        endcase
    end

    // Release wins over preemption; preempt is only ever a single-cycle pulse.
    always_comb begin
        gnt_nxt      = gnt;
        gnt_vld_nxt  = gnt_vld;
        gnt_idx_nxt  = gnt_idx;
        preempt_nxt  = 1'b0;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        unique case (state)
            IDLE, GAP: begin
                if (found_full) begin
                    gnt_nxt      = sel;
                    gnt_vld_nxt  = 1'b1;
                    gnt_idx_nxt  = sel_idx;
                    ptr_nxt      = sel_idx;
                    hold_cnt_nxt = '0;
                end else begin
                    gnt_nxt     = '0;
                    gnt_vld_nxt = 1'b0;
                    gnt_idx_nxt = '0;
                end
            end
            GRANT: begin
                if (!holder_req || hold_expired) begin
                    gnt_nxt     = '0;
                    gnt_vld_nxt = 1'b0;
                    gnt_idx_nxt = '0;
                    preempt_nxt = holder_req;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                gnt_nxt     = '0;
                gnt_vld_nxt = 1'b0;
                gnt_idx_nxt = '0;
            end
        endcase
    end

endmodule
